// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
// Shared definitions for the register bank: clear-sweep FSM state
// encodings and the address-width helper used by the interface and the top.
package reg_bank_pkg;

  // Clear-sweep FSM states, kept as plain constants so older tools and
  // waveform scripts see a fixed 2-bit encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Address width for a bank of 'depth' entries; never narrower than 1 bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// reg_bank_if
// Bundles the write, read, visibility and clear-sweep signals of reg_bank.
// Ports (slave view, as seen by reg_bank):
//   wr_en, wr_addr, wr_data          write port
//   rd_en, rd_hold, rd_addr, rd_data latched read port
//   vis_oe, vis_addr, vis_data       combinational display port
//   clr_all, busy, clr_done          clear-sweep control/status
interface reg_bank_if
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = addr_w(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             rd_hold;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             vis_oe;
  logic [AW-1:0]    vis_addr;
  logic [WIDTH-1:0] vis_data;
  logic             clr_all;
  logic             busy;
  logic             clr_done;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en, rd_hold, rd_addr,
    output vis_oe, vis_addr,
    output clr_all,
    input  rd_data, vis_data, busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_hold, rd_addr,
    input  vis_oe, vis_addr,
    input  clr_all,
    output rd_data, vis_data, busy, clr_done
  );

endinterface

// File: rtl/reg_cell.sv
// reg_cell
// One WIDTH-bit storage register with synchronous load enable and
// synchronous clear to RESET_VAL; the multi-bit form of the old set/clear cell.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset (loads RESET_VAL)
//   clr  in   synchronous clear to RESET_VAL (used by the clear sweep)
//   ld   in   load enable
//   d    in   load data
//   q    out  stored value
module reg_cell
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear outranks load so a sweep can never be undone by a stray write.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= RESET_VAL;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// reg_bank
// Bank of DEPTH registers of WIDTH bits with one write port, one latched
// read port, an always-on visibility port and a one-entry-per-cycle
// clear-all sweep.
// Ports:
//   clk  in   single rising-edge clock
//   rst  in   synchronous active-high reset, overrides everything
//   bus  slave view of reg_bank_if (write/read/visibility/sweep signals)
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic      clk,
  input  logic      rst,
  reg_bank_if.slave bus
);

  localparam int AW = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [1:0]       state;
  logic [AW-1:0]    idx;
  logic             sweeping;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] vis_mux;
  logic [WIDTH-1:0] rd_q;

  assign sweeping     = (state == ST_SWEEP);
  assign bus.busy     = sweeping;
  assign bus.clr_done = (state == ST_DONE);

  // Storage cells. Address decode is by equality per entry, so addresses
  // at or beyond DEPTH simply match no cell and are dropped.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    logic cell_clr;
    logic cell_ld;

    assign cell_clr = sweeping && (idx == AW'(g));
    assign cell_ld  = bus.wr_en && !sweeping && (bus.wr_addr == AW'(g));

    reg_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .clr (cell_clr),
      .ld  (cell_ld),
      .d   (bus.wr_data),
      .q   (mem_q[g])
    );
  end

  // Read and visibility muxes; an unmatched address yields 0.
  always_comb begin
    rd_mux  = '0;
    vis_mux = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.rd_addr == AW'(i)) begin
        rd_mux = mem_q[i];
      end
      if (bus.vis_oe && (bus.vis_addr == AW'(i))) begin
        vis_mux = mem_q[i];
      end
    end
  end

  assign bus.vis_data = vis_mux;

  // Read latch. It samples the cell outputs before this edge's write lands,
  // so a same-cycle read of the written address returns the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (bus.rd_en && !bus.rd_hold) begin
      rd_q <= rd_mux;
    end
  end

  assign bus.rd_data = rd_q;

  // Clear-sweep sequencer: IDLE waits for clr_all, SWEEP clears entry idx
  // each cycle for DEPTH cycles, DONE flags completion for one cycle.
  // clr_all is only looked at in IDLE, so it cannot restart a sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.clr_all) begin
            state <= ST_SWEEP;
            idx   <= '0;
          end
        end
        ST_SWEEP: begin
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
            idx   <= '0;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank
// Drives an 8-entry and a 6-entry reg_bank with identical stimulus and
// compares both against a behavioural model of the bank kept here.
module tb_reg_bank;

  logic clk;
  logic rst;

  reg_bank_if #(.WIDTH(8), .DEPTH(8)) bus8 ();
  reg_bank_if #(.WIDTH(8), .DEPTH(6)) bus6 ();

  reg_bank #(.WIDTH(8), .DEPTH(8), .RESET_VAL(8'h00)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  reg_bank #(.WIDTH(8), .DEPTH(6), .RESET_VAL(8'h00)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model, index 0 = 8-entry bank, index 1 = 6-entry bank.
  // m_pos is the entry the sweep will clear next, -1 when no sweep runs.
  int m_depth [2] = '{8, 6};
  int m_mem   [2][8];
  int m_rd    [2];
  int m_pos   [2];
  bit m_done  [2];
  bit model_valid = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int visExpect(input int d, input bit vo, input int va);
    return (vo && va < m_depth[d]) ? m_mem[d][va] : 0;
  endfunction

  // Advances the model by one clock edge using the inputs held across it.
  function automatic void modelEdge(input bit r, input bit we, input int wa,
                                    input int wd, input bit re, input bit rh,
                                    input int ra, input bit ca);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        for (int a = 0; a < 8; a++) m_mem[d][a] = 0;
        m_rd[d]   = 0;
        m_pos[d]  = -1;
        m_done[d] = 1'b0;
      end else begin
        int next_rd;
        next_rd = m_rd[d];
        if (re && !rh) next_rd = (ra < m_depth[d]) ? m_mem[d][ra] : 0;
        if (we && m_pos[d] < 0 && wa < m_depth[d]) m_mem[d][wa] = wd;
        if (m_pos[d] >= 0) begin
          m_mem[d][m_pos[d]] = 0;
          if (m_pos[d] == m_depth[d] - 1) begin
            m_pos[d]  = -1;
            m_done[d] = 1'b1;
          end else begin
            m_pos[d]++;
          end
        end else if (m_done[d]) begin
          m_done[d] = 1'b0;
        end else if (ca) begin
          m_pos[d] = 0;
        end
        m_rd[d] = next_rd;
      end
    end
  endfunction

  // One clock of stimulus: drive inputs, check the combinational view,
  // let the edge happen, then check the registered outputs.
  task automatic applyStimulus(input bit r, input bit we, input int wa, input int wd,
                               input bit re, input bit rh, input int ra,
                               input bit vo, input int va, input bit ca);
    rst           = r;
    bus8.wr_en    = we;  bus6.wr_en    = we;
    bus8.wr_addr  = 3'(wa); bus6.wr_addr  = 3'(wa);
    bus8.wr_data  = 8'(wd); bus6.wr_data  = 8'(wd);
    bus8.rd_en    = re;  bus6.rd_en    = re;
    bus8.rd_hold  = rh;  bus6.rd_hold  = rh;
    bus8.rd_addr  = 3'(ra); bus6.rd_addr  = 3'(ra);
    bus8.vis_oe   = vo;  bus6.vis_oe   = vo;
    bus8.vis_addr = 3'(va); bus6.vis_addr = 3'(va);
    bus8.clr_all  = ca;  bus6.clr_all  = ca;
    #1;
    if (model_valid) begin
      checkOutput("vis_data d8", 32'(bus8.vis_data), 32'(visExpect(0, vo, va)));
      checkOutput("vis_data d6", 32'(bus6.vis_data), 32'(visExpect(1, vo, va)));
    end
    @(posedge clk);
    modelEdge(r, we, wa, wd, re, rh, ra, ca);
    if (r) model_valid = 1'b1;
    #1;
    if (model_valid) begin
      checkOutput("rd_data d8",  32'(bus8.rd_data),  32'(m_rd[0]));
      checkOutput("rd_data d6",  32'(bus6.rd_data),  32'(m_rd[1]));
      checkOutput("busy d8",     32'(bus8.busy),     32'(m_pos[0] >= 0));
      checkOutput("busy d6",     32'(bus6.busy),     32'(m_pos[1] >= 0));
      checkOutput("clr_done d8", 32'(bus8.clr_done), 32'(m_done[0]));
      checkOutput("clr_done d6", 32'(bus6.clr_done), 32'(m_done[1]));
    end
  endtask

  initial begin
    int b8, b6, p8, p6;
    int data;

    $display("[TB] reg_bank bench start");

    // Reset, then read every address with the display disabled.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, a, 0, $urandom_range(0, 7), 0);
      checkOutput("reset readback", 32'(bus8.rd_data), 32'h0);
    end

    // Same-cycle read/write returns old data, then the new value.
    applyStimulus(0, 1, 3, 'hA5, 1, 0, 3, 0, 0, 0);
    checkOutput("read-during-write old", 32'(bus8.rd_data), 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 3, 1, 3, 0);
    checkOutput("read after write", 32'(bus8.rd_data), 32'hA5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);

    // Read latch held across a write and a further read request.
    applyStimulus(0, 0, 0, 0, 1, 0, 3, 1, 3, 0);
    applyStimulus(0, 1, 3, 'h3C, 1, 1, 3, 1, 3, 0);
    checkOutput("hold over write", 32'(bus8.rd_data), 32'hA5);
    applyStimulus(0, 0, 0, 0, 1, 1, 3, 1, 3, 0);
    checkOutput("hold over read", 32'(bus8.rd_data), 32'hA5);
    applyStimulus(0, 0, 0, 0, 1, 0, 3, 1, 3, 0);
    checkOutput("hold released", 32'(bus8.rd_data), 32'h3C);

    // Out-of-range write/read on the 6-entry bank.
    applyStimulus(0, 1, 7, 'h77, 0, 0, 0, 1, 7, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 7, 1, 7, 0);
    checkOutput("oor read d6", 32'(bus6.rd_data), 32'h0);
    checkOutput("in-range read d8", 32'(bus8.rd_data), 32'h77);

    // Fill, sweep with writes and repeated clr_all while busy.
    for (int a = 0; a < 8; a++) begin
      data = $urandom_range(1, 255);
      applyStimulus(0, 1, a, data, 0, 0, 0, 1, a, 0);
    end
    b8 = 0; b6 = 0; p8 = 0; p6 = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    b8 += int'(bus8.busy); b6 += int'(bus6.busy);
    for (int s = 1; s < 12; s++) begin
      applyStimulus(0, (s < 6), $urandom_range(0, 7), $urandom_range(1, 255),
                    1, 0, $urandom_range(0, 7), 1, $urandom_range(0, 7),
                    (s < 4) ? 1'($urandom_range(0, 1)) : 1'b0);
      b8 += int'(bus8.busy);     b6 += int'(bus6.busy);
      p8 += int'(bus8.clr_done); p6 += int'(bus6.clr_done);
    end
    checkOutput("busy cycles d8", 32'(b8), 32'd8);
    checkOutput("busy cycles d6", 32'(b6), 32'd6);
    checkOutput("done pulses d8", 32'(p8), 32'd1);
    checkOutput("done pulses d6", 32'(p6), 32'd1);
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, a, 1, a, 0);
      checkOutput("post-sweep read d8", 32'(bus8.rd_data), 32'h0);
    end

    // Reset in the middle of a sweep.
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 1, a, $urandom_range(1, 255), 0, 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int s = 0; s < 3; s++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("busy after mid rst", 32'(bus8.busy), 32'h0);
    p8 = 0; p6 = 0;
    for (int a = 0; a < 10; a++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, a % 8, 1, a % 8, 0);
      p8 += int'(bus8.clr_done); p6 += int'(bus6.clr_done);
    end
    checkOutput("no done after rst d8", 32'(p8), 32'd0);
    checkOutput("no done after rst d6", 32'(p6), 32'd0);

    // Random traffic against the model.
    for (int s = 0; s < 400; s++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 255),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7),
                    ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
